lsu_word_access: RTL and testbench

Load/store access sequencer between the pipeline MEM stage and the 8-bit `data_memory`. It accepts one byte or 16-bit halfword load/store request per handshake. It splits each halfword into two little-endian byte accesses on the memory's single shared address port, then returns a zero-extended 16-bit load result with a one-cycle response pulse. It is the initiator side of the data-memory port: it drives address, write data, write enable and read enable, and samples the combinational read data.

---
 rtl/lsu_word_access.sv | 154 +++++++++++++++
 tb/tb_lsu_word_access.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_word_access.sv
// lsu_word_access: load/store sequencer between the MEM stage and an 8-bit
// data memory with one shared address port. A halfword becomes two
// little-endian byte accesses: the low byte in LO, then the high byte in HI.
// A load returns a zero-extended 16-bit result with a one-cycle resp_valid
// pulse.
// Optional feature macro: LSU_ALIGN_CHECK_EN. When it is defined, an odd
// halfword request is answered with resp_err and makes no memory access.
module lsu_word_access #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic          req_half,
    input  logic [AW-1:0] req_addr,
    input  logic [15:0]   req_wdata,
    output logic          resp_valid,
    output logic [15:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_access_addr,
    output logic [7:0]    mem_write_data,
    output logic          mem_write_en,
    output logic          mem_read,
    input  logic [7:0]    mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          write_q, half_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   data_q, data_d;
    logic          resp_valid_q;
    logic [15:0]   resp_rdata_q;
    logic          accept;
    logic          misaligned;
    logic          done;

    assign accept = (state_q == S_IDLE) && req_valid;

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = req_half && req_addr[0];
`else
    assign misaligned = 1'b0;
`endif

    // Next-state and memory-side decode from the current state and latched fields
    always_comb begin
        state_d         = state_q;
        data_d          = data_q;
        done            = 1'b0;
        req_ready       = 1'b0;
        mem_access_addr = addr_q;
        mem_write_data  = 8'h00;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    data_d  = 16'h0000;
                    // A rejected misaligned request stays in IDLE; its error response is registered below
                    state_d = misaligned ? S_IDLE : S_LO;
                end
            end
            S_LO: begin
                mem_write_en   = write_q;
                mem_read       = !write_q;
                mem_write_data = write_q ? wdata_q[7:0] : 8'h00;
                if (!write_q) begin
                    data_d[7:0] = mem_read_data;
                end
                if (half_q) begin
                    state_d = S_HI;
                end else begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            S_HI: begin
                // The address arithmetic is AW bits wide, so the top address wraps to zero
                mem_access_addr = addr_q + AW'(1);
                mem_write_en    = write_q;
                mem_read        = !write_q;
                mem_write_data  = write_q ? wdata_q[15:8] : 8'h00;
                if (!write_q) begin
                    data_d[15:8] = mem_read_data;
                end
                state_d = S_IDLE;
                done    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, request latch, data capture and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            half_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 16'h0000;
            data_q       <= 16'h0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            resp_valid_q <= done || (accept && misaligned);
            if (accept) begin
                write_q <= req_write;
                half_q  <= req_half;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (done) begin
                resp_rdata_q <= write_q ? 16'h0000 : data_d;
            end else if (accept && misaligned) begin
                resp_rdata_q <= 16'h0000;
            end
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    logic resp_err_q;

    // The error flag accompanies every response: set for a rejected request, clear otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_q <= 1'b0;
        end else if (done || accept) begin
            resp_err_q <= accept && misaligned;
        end
    end

    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_word_access.sv
// Directed bench for lsu_word_access with an 8-bit data memory model.
// A scoreboard queue holds the expected response of each accepted request.
module tb_lsu_word_access;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write, req_half;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic          resp_valid, resp_err;
    logic [15:0]   resp_rdata;
    logic [AW-1:0] mem_access_addr;
    logic [7:0]    mem_write_data, mem_read_data;
    logic          mem_write_en, mem_read;

    lsu_word_access #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_half(req_half), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(int i);
        logic [7:0] v;
        v = 8'(i * 7 + 3);
        if (i == 100) v = 8'hFE;
        if (i == 101) v = 8'h00;
        if (i == 119) v = 8'hFF;
        return v;
    endfunction

    // Memory: preloaded on the first clock edge, then written by the DUT strobe
    logic [7:0] mem [256];
    logic       preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
            preloaded <= 1'b1;
        end else if (mem_write_en) begin
            mem[mem_access_addr] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_access_addr];

    logic [7:0] model [256];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    exp_t       sb[$];
    exp_t       pop_e, push_e;
    int         acc_cyc[$];
    int         resp_cyc[$];
    logic [7:0] rd_log[$];
    logic [7:0] wr_log[$];
    logic       mon_bad;
    logic [7:0] mon_a1;

    // Monitor: check responses, log memory strobes, then predict any request accepted at the next edge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (mem_read) rd_log.push_back(mem_access_addr);
            if (mem_write_en) wr_log.push_back(mem_access_addr);
            if (resp_valid) begin
                resp_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_resp", sb.size(), 1);
                end else begin
                    pop_e = sb.pop_front();
                    check("resp_rdata", resp_rdata, pop_e.rdata);
                    check("resp_err", resp_err, pop_e.err);
                    check("resp_latency", cyc, pop_e.at);
                end
            end else if (sb.size() != 0 && cyc > sb[0].at) begin
                check("resp_timeout", resp_valid, 1);
                pop_e = sb.pop_front();
            end
            if (req_valid && req_ready) begin
                mon_bad = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
                mon_bad = req_half && req_addr[0];
`endif
                mon_a1 = req_addr + 8'd1;
                push_e.err = mon_bad;
                if (req_write || mon_bad) push_e.rdata = 16'h0000;
                else if (req_half)        push_e.rdata = {model[mon_a1], model[req_addr]};
                else                      push_e.rdata = {8'h00, model[req_addr]};
                push_e.at = cyc + 1 + ((req_half && !mon_bad) ? 2 : 1);
                sb.push_back(push_e);
                acc_cyc.push_back(cyc + 1);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check("ready_timeout", req_ready, 1);
    endtask

    task automatic issue(logic w, logic h, logic [7:0] a, logic [15:0] d);
        logic [7:0] a1;
        logic       bad;
        a1  = a + 8'd1;
        bad = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        bad = h && a[0];
`endif
        wait_ready();
        req_write = w; req_half = h; req_addr = a; req_wdata = d; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = 16'hDEAD;
        req_addr  = 8'h77;
        if (w && !bad) begin
            model[a] = d[7:0];
            if (h) model[a1] = d[15:8];
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    int base_rd, base_wr, base_acc, base_resp, mism;
    logic [7:0] old0, old255, old11;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_half = 1'b0;
        req_addr = '0; req_wdata = 16'h0000;
        for (int i = 0; i < 256; i++) model[i] = init_byte(i);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_we", mem_write_en, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_addr", mem_access_addr, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Halfword load at 100
        base_rd = rd_log.size();
        issue(1'b0, 1'b1, 8'd100, 16'h0);
        drain();
        check("hload_rdata", resp_rdata, 16'h00FE);
        check("hload_rd_cycles", rd_log.size() - base_rd, 2);
        check("hload_rd_addr0", rd_log[base_rd], 100);
        check("hload_rd_addr1", rd_log[base_rd + 1], 101);
        repeat (2) @(posedge clk);
        #1;
        check("rdata_hold", resp_rdata, 16'h00FE);
        check("resp_pulse_low", resp_valid, 0);

        // Halfword store then load at 50
        base_wr = wr_log.size();
        issue(1'b1, 1'b1, 8'd50, 16'hA55A);
        drain();
        check("hstore_we_cycles", wr_log.size() - base_wr, 2);
        check("hstore_mem50", mem[50], 8'h5A);
        check("hstore_mem51", mem[51], 8'hA5);
        check("hstore_rdata_zero", resp_rdata, 0);
        issue(1'b0, 1'b1, 8'd50, 16'h0);
        drain();
        check("hload50_rdata", resp_rdata, 16'hA55A);

        // Byte load at 119, byte store at 102
        issue(1'b0, 1'b0, 8'd119, 16'h0);
        drain();
        check("bload_rdata", resp_rdata, 16'h00FF);
        issue(1'b1, 1'b0, 8'd102, 16'hCC33);
        drain();
        check("bstore_mem102", mem[102], 8'h33);
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) mism++;
        check("mem_image", mism, 0);

        // Halfword store at 255
        old255 = mem[255]; old0 = mem[0];
        base_wr = wr_log.size();
        issue(1'b1, 1'b1, 8'd255, 16'h1234);
        drain();
`ifdef LSU_ALIGN_CHECK_EN
        check("wrap_err_flag", resp_err, 1);
        check("wrap_no_write", wr_log.size() - base_wr, 0);
        check("wrap_mem255", mem[255], old255);
        check("wrap_mem0", mem[0], old0);
`else
        check("wrap_mem255", mem[255], 8'h34);
        check("wrap_mem0", mem[0], 8'h12);
        check("wrap_err_flag", resp_err, 0);
`endif
        issue(1'b0, 1'b1, 8'd255, 16'h0);
        drain();

        // Back-to-back halfword loads with req_valid held high
        base_acc = acc_cyc.size(); base_resp = resp_cyc.size();
        wait_ready();
        req_write = 1'b0; req_half = 1'b1; req_addr = 8'd100; req_valid = 1'b1;
        for (int n = 0; n < 30 && (acc_cyc.size() - base_acc) < 3; n++) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc_cyc.size() - base_acc, 3);
        check("b2b_ready_lo", req_ready, 0);
        @(posedge clk); #1;
        check("b2b_ready_hi", req_ready, 0);
        drain();
        check("b2b_acc_gap1", acc_cyc[base_acc + 1] - acc_cyc[base_acc], 3);
        check("b2b_acc_gap2", acc_cyc[base_acc + 2] - acc_cyc[base_acc + 1], 3);
        check("b2b_resps", resp_cyc.size() - base_resp, 3);
        check("b2b_resp_gap1", resp_cyc[base_resp + 1] - resp_cyc[base_resp], 3);
        check("b2b_resp_gap2", resp_cyc[base_resp + 2] - resp_cyc[base_resp + 1], 3);

        // Reset during the HI cycle of a halfword store
        old11 = mem[11];
        wait_ready();
        req_write = 1'b1; req_half = 1'b1; req_addr = 8'd10; req_wdata = 16'hBEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_lo_we", mem_write_en, 1);
        check("rst_lo_addr", mem_access_addr, 10);
        @(posedge clk); #1;
        check("rst_hi_we", mem_write_en, 1);
        check("rst_hi_addr", mem_access_addr, 11);
        check("rst_hi_wdata", mem_write_data, 8'hBE);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_we", mem_write_en, 0);
        check("rst_async_ready", req_ready, 1);
        base_resp = resp_cyc.size();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model[10] = 8'hEF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem10", mem[10], 8'hEF);
        check("rst_mem11", mem[11], old11);
        check("rst_no_resp", resp_cyc.size() - base_resp, 0);
        check("rst_ready_after", req_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
